// File: rtl/stream_run_source_pkg.sv
// ---------------------------------------------------------------------------
// source_config: shared definitions for the stream_run_source slice.
//
// Contents:
//   - default network geometry (NET_NUM_INP, NET_CHARGE_WIDTH)
//   - flag enum: bit positions of the opcode flags counted from the packet MSB
//   - state enum for the sequencing FSM
//   - helper functions that derive the packet width and field offsets from
//     the block parameters
//
// Packet layout, MSB first: CLR flag, DEC flag, run count, channel 0 charge,
// channel 1 charge, ..., last channel charge at the LSBs.
// ---------------------------------------------------------------------------
package source_config;

  localparam int NET_NUM_INP      = 2;
  localparam int NET_CHARGE_WIDTH = 8;

  // Flags are indexed from the MSB downwards.
  typedef enum int {
    FLAG_CLR = 0,
    FLAG_DEC = 1
  } flag_e;

  localparam int OPC_WIDTH = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_DEC   = 3'd2,
    S_APPLY = 3'd3,
    S_RUN   = 3'd4
  } state_e;

  function automatic int pkt_width(input int num_inp, input int charge_width,
                                   input int run_width);
    return OPC_WIDTH + run_width + num_inp * charge_width;
  endfunction

  function automatic int flag_bit(input int pkt_w, input flag_e f);
    return pkt_w - 1 - int'(f);
  endfunction

  // Run count sits directly above the charge block.
  function automatic int run_lsb(input int num_inp, input int charge_width);
    return num_inp * charge_width;
  endfunction

  // Channel 0 is the most significant charge; the last channel is at bit 0.
  function automatic int chan_lsb(input int num_inp, input int charge_width,
                                  input int idx);
    return (num_inp - 1 - idx) * charge_width;
  endfunction

endpackage

// File: rtl/stream_run_source_if.sv
// ---------------------------------------------------------------------------
// stream_run_source_if: host-side and network-side signals of the run source.
//
// Signals:
//   src_valid / src_ready / src   host packet handshake
//   out_ready                     one-cycle decision-capture pulse to the sink
//   net_ready                     network accepts the current cycle / clear
//   net_valid / net_clr           network cycle valid / clear request
//   net_inp[i]                    per-channel signed charge (channel i)
//
// Modports:
//   master - the run source itself
//   slave  - the environment (host + network)
// ---------------------------------------------------------------------------
interface stream_run_source_if
  import source_config::*;
#(
  parameter int NUM_INP      = NET_NUM_INP,
  parameter int CHARGE_WIDTH = NET_CHARGE_WIDTH,
  parameter int RUN_WIDTH    = 8
);
  localparam int PKT_WIDTH = pkt_width(NUM_INP, CHARGE_WIDTH, RUN_WIDTH);

  logic                                   src_valid;
  logic                                   src_ready;
  logic [PKT_WIDTH-1:0]                   src;
  logic                                   out_ready;
  logic                                   net_ready;
  logic                                   net_valid;
  logic                                   net_clr;
  logic [NUM_INP-1:0][CHARGE_WIDTH-1:0]   net_inp;

  modport master (
    input  src_valid, src, net_ready,
    output src_ready, out_ready, net_valid, net_clr, net_inp
  );

  modport slave (
    output src_valid, src, net_ready,
    input  src_ready, out_ready, net_valid, net_clr, net_inp
  );

endinterface

// File: rtl/stream_run_source_ctr.sv
// ---------------------------------------------------------------------------
// stream_run_ctr: loadable down-counter for the idle run phase.
//
// Ports:
//   clk, arstn      clock, asynchronous active-low reset
//   load_i          load load_val_i (takes priority over dec_i)
//   load_val_i      value to load
//   dec_i           decrement by one; saturates at zero so it can never wrap
//   is_one_o        counter currently holds 1 (final run beat)
// ---------------------------------------------------------------------------
module stream_run_ctr #(
  parameter int RUN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 arstn,
  input  logic                 load_i,
  input  logic [RUN_WIDTH-1:0] load_val_i,
  input  logic                 dec_i,
  output logic                 is_one_o
);

  logic [RUN_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - RUN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one_o = (cnt_q == RUN_WIDTH'(1));

endmodule

// File: rtl/stream_run_source.sv
// ---------------------------------------------------------------------------
// stream_run_source: turns one host packet into a network sequence
//   [clear] -> [decision request] -> one charge-apply cycle -> R idle cycles.
//
// Ports:
//   clk    clock
//   arstn  asynchronous active-low reset
//   bus    stream_run_source_if.master (host handshake + network outputs)
//
// The packet is held in a register, so the host is only asked for a new
// packet in IDLE or on the final network beat of the current one. That final
// beat depends on net_ready, which makes src_ready the only combinational
// output; everything else decodes from registered state.
// ---------------------------------------------------------------------------
module stream_run_source
  import source_config::*;
#(
  parameter int NUM_INP      = NET_NUM_INP,
  parameter int CHARGE_WIDTH = NET_CHARGE_WIDTH,
  parameter int RUN_WIDTH    = 8
) (
  input logic                 clk,
  input logic                 arstn,
  stream_run_source_if.master bus
);

  localparam int PKT_WIDTH = pkt_width(NUM_INP, CHARGE_WIDTH, RUN_WIDTH);
  localparam int CLR_BIT   = flag_bit(PKT_WIDTH, FLAG_CLR);
  localparam int DEC_BIT   = flag_bit(PKT_WIDTH, FLAG_DEC);
  localparam int RUN_LSB   = run_lsb(NUM_INP, CHARGE_WIDTH);
  // The clear flag only steers the entry state, so it is not held.
  localparam int HELD_WIDTH = PKT_WIDTH - 1;

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_CLR   = S_CLR;
  localparam logic [2:0] ST_DEC   = S_DEC;
  localparam logic [2:0] ST_APPLY = S_APPLY;
  localparam logic [2:0] ST_RUN   = S_RUN;

  logic [2:0]            state_q, state_d;
  logic [HELD_WIDTH-1:0] pkt_q, pkt_d;
  logic [RUN_WIDTH-1:0]  run_len;
  logic                  cnt_is_one;
  logic                  last_beat;
  logic                  src_ready;
  logic                  accept;
  logic                  ctr_load;
  logic                  ctr_dec;

  assign run_len = pkt_q[RUN_LSB +: RUN_WIDTH];

  assign last_beat = bus.net_ready &
                     (((state_q == ST_APPLY) & (run_len == '0)) |
                      ((state_q == ST_RUN) & cnt_is_one));
  assign src_ready     = (state_q == ST_IDLE) | last_beat;
  assign accept        = bus.src_valid & src_ready;
  assign bus.src_ready = src_ready;

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    case (state_q)
      ST_CLR:   if (bus.net_ready) state_d = pkt_q[DEC_BIT] ? ST_DEC : ST_APPLY;
      ST_DEC:   state_d = ST_APPLY;
      ST_APPLY: if (bus.net_ready) state_d = (run_len == '0) ? ST_IDLE : ST_RUN;
      ST_RUN:   if (bus.net_ready && cnt_is_one) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Accept overrides the return to IDLE so back-to-back packets have no bubble.
    if (accept) begin
      pkt_d   = bus.src[HELD_WIDTH-1:0];
      state_d = bus.src[CLR_BIT] ? ST_CLR :
                (bus.src[DEC_BIT] ? ST_DEC : ST_APPLY);
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= ST_IDLE;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
    end
  end

  // The run counter is loaded on the charge-apply beat and counts the
  // remaining idle beats, so the final one is seen when it reads 1.
  assign ctr_load = (state_q == ST_APPLY) & bus.net_ready & (run_len != '0);
  assign ctr_dec  = (state_q == ST_RUN) & bus.net_ready;

  stream_run_ctr #(
    .RUN_WIDTH (RUN_WIDTH)
  ) u_ctr (
    .clk        (clk),
    .arstn      (arstn),
    .load_i     (ctr_load),
    .load_val_i (run_len),
    .dec_i      (ctr_dec),
    .is_one_o   (cnt_is_one)
  );

  assign bus.net_clr   = (state_q == ST_CLR);
  assign bus.out_ready = (state_q == ST_DEC);
  assign bus.net_valid = (state_q == ST_APPLY) | (state_q == ST_RUN);

  // Charges are driven only on the apply beat; run beats carry zero charge.
  for (genvar gi = 0; gi < NUM_INP; gi++) begin : g_chan
    localparam int LSB = chan_lsb(NUM_INP, CHARGE_WIDTH, gi);
    assign bus.net_inp[gi] = (state_q == ST_APPLY) ?
                             pkt_q[LSB +: CHARGE_WIDTH] : '0;
  end

endmodule

// File: tb/tb_stream_run_source.sv
// ---------------------------------------------------------------------------
// tb_stream_run_source: directed steps followed by randomized packets.
// Each accepted packet is expanded into the list of network events it must
// produce (clear, decision pulse, charge transfer, R zero transfers); the
// events actually observed are matched against that list in order.
// ---------------------------------------------------------------------------
module tb_stream_run_source;

  localparam int NI = 2;
  localparam int CW = 8;
  localparam int RW = 4;
  localparam int PW = 2 + RW + NI * CW;

  typedef struct {
    int          kind;   // 0 clear, 1 decision pulse, 2 transfer
    logic [15:0] data;   // {ch0, ch1} for transfers
  } ev_t;

  logic clk;
  logic arstn;
  int   total;
  int   bad;
  int   xfers;
  ev_t  exp_q[$];

  stream_run_source_if #(.NUM_INP(NI), .CHARGE_WIDTH(CW), .RUN_WIDTH(RW)) bus ();

  stream_run_source #(.NUM_INP(NI), .CHARGE_WIDTH(CW), .RUN_WIDTH(RW)) dut (
    .clk   (clk),
    .arstn (arstn),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mk(input logic clr, input logic dec,
                                       input logic [3:0] r,
                                       input logic [7:0] c0, input logic [7:0] c1);
    return {clr, dec, r, c0, c1};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic expand(input logic [PW-1:0] p);
    ev_t e;
    e.data = '0;
    if (p[PW-1]) begin e.kind = 0; exp_q.push_back(e); end
    if (p[PW-2]) begin e.kind = 1; exp_q.push_back(e); end
    e.kind = 2;
    e.data = p[15:0];
    exp_q.push_back(e);
    e.data = '0;
    for (int i = 0; i < int'(p[19:16]); i++) exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [15:0] data);
    ev_t e;
    check("evt_expected", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("evt_kind", kind, e.kind);
      check("evt_data", 32'(data), 32'(e.data));
    end
  endtask

  task automatic drive(input logic v, input logic [PW-1:0] s, input logic nr);
    bus.src_valid = v;
    bus.src       = s;
    bus.net_ready = nr;
    #1;
  endtask

  // Score the current (settled) cycle, then move to just after the next edge.
  task automatic cycle();
    if (arstn) begin
      check("mutex", 32'($countones({bus.net_clr, bus.out_ready, bus.net_valid}) <= 1), 32'd1);
      if (bus.net_clr && bus.net_ready) observe(0, 16'h0);
      if (bus.out_ready) observe(1, 16'h0);
      if (bus.net_valid && bus.net_ready) begin
        observe(2, {bus.net_inp[0], bus.net_inp[1]});
        xfers++;
      end
      if (bus.src_valid && bus.src_ready) expand(bus.src);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_src_ready"}, 32'(bus.src_ready), 32'd1);
    check({tag, "_net_valid"}, 32'(bus.net_valid), 32'd0);
    check({tag, "_net_clr"},   32'(bus.net_clr),   32'd0);
    check({tag, "_out_ready"}, 32'(bus.out_ready), 32'd0);
    check({tag, "_net_inp"},   32'({bus.net_inp[0], bus.net_inp[1]}), 32'd0);
  endtask

  initial begin
    int x0;
    int sent;
    bit have;
    logic v;
    logic [PW-1:0] pend;
    logic [3:0] r;

    total = 0;
    bad   = 0;
    xfers = 0;
    arstn = 1'b0;
    drive(1'b0, '0, 1'b0);
    check_idle("reset");
    repeat (2) cycle();
    arstn = 1'b1;

    // 1: single-beat packet, then a back-to-back second packet
    drive(1'b1, mk(0, 0, 4'd0, 8'd5, 8'hFD), 1'b1);
    check("t1_src_ready_idle", 32'(bus.src_ready), 32'd1);
    cycle();
    drive(1'b1, mk(0, 0, 4'd0, 8'd1, 8'd1), 1'b1);
    check("t1_valid_a", 32'(bus.net_valid), 32'd1);
    check("t1_inp_a", 32'({bus.net_inp[0], bus.net_inp[1]}), 32'h05FD);
    check("t1_src_ready_a", 32'(bus.src_ready), 32'd1);
    cycle();
    drive(1'b0, '0, 1'b1);
    check("t1_valid_b", 32'(bus.net_valid), 32'd1);
    check("t1_inp_b", 32'({bus.net_inp[0], bus.net_inp[1]}), 32'h0101);
    cycle();
    drive(1'b0, '0, 1'b1);
    check("t1_idle", 32'(bus.net_valid), 32'd0);

    // 2: R=3 gives four transfers, src_ready only on the last
    drive(1'b1, mk(0, 0, 4'd3, 8'd5, 8'hFD), 1'b1);
    cycle();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b1);
      check("t2_valid", 32'(bus.net_valid), 32'd1);
      check("t2_inp", 32'({bus.net_inp[0], bus.net_inp[1]}), (k == 0) ? 32'h05FD : 32'h0);
      check("t2_src_ready", 32'(bus.src_ready), (k == 3) ? 32'd1 : 32'd0);
      cycle();
    end
    drive(1'b0, '0, 1'b1);
    check("t2_idle", 32'(bus.net_valid), 32'd0);

    // 3: clear, then decision pulse, then apply
    drive(1'b1, mk(1, 1, 4'd0, 8'd7, 8'd0), 1'b1);
    cycle();
    drive(1'b0, '0, 1'b1);
    check("t3_clr", 32'({bus.net_clr, bus.out_ready, bus.net_valid}), 32'b100);
    cycle();
    drive(1'b0, '0, 1'b1);
    check("t3_dec", 32'({bus.net_clr, bus.out_ready, bus.net_valid}), 32'b010);
    cycle();
    drive(1'b0, '0, 1'b1);
    check("t3_apply", 32'({bus.net_clr, bus.out_ready, bus.net_valid}), 32'b001);
    check("t3_inp", 32'({bus.net_inp[0], bus.net_inp[1]}), 32'h0700);
    cycle();

    // 4: stalls in CLR, APPLY and RUN
    x0 = xfers;
    drive(1'b1, mk(1, 0, 4'd2, 8'd9, 8'hFF), 1'b1);
    cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b0);
      check("t4_clr_hold", 32'(bus.net_clr), 32'd1);
      check("t4_clr_srdy", 32'(bus.src_ready), 32'd0);
      cycle();
    end
    drive(1'b0, '0, 1'b1);
    cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b0);
      check("t4_apply_hold", 32'(bus.net_valid), 32'd1);
      check("t4_apply_inp", 32'({bus.net_inp[0], bus.net_inp[1]}), 32'h09FF);
      cycle();
    end
    drive(1'b0, '0, 1'b1);
    cycle();
    drive(1'b0, '0, 1'b1);
    check("t4_run_srdy_first", 32'(bus.src_ready), 32'd0);
    cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b0);
      check("t4_run_hold", 32'(bus.net_valid), 32'd1);
      check("t4_run_srdy", 32'(bus.src_ready), 32'd0);
      cycle();
    end
    drive(1'b0, '0, 1'b1);
    check("t4_run_last_srdy", 32'(bus.src_ready), 32'd1);
    cycle();
    drive(1'b0, '0, 1'b1);
    check("t4_idle", 32'(bus.net_valid), 32'd0);
    check("t4_count", xfers - x0, 32'd3);

    // 5: maximum run length
    x0 = xfers;
    drive(1'b1, mk(0, 0, 4'd15, 8'd1, 8'd2), 1'b1);
    cycle();
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, '0, 1'b1);
      if (!bus.net_valid) break;
      cycle();
    end
    check("t5_count", xfers - x0, 32'd16);
    check("t5_idle", 32'(bus.net_valid), 32'd0);
    check("t5_srdy", 32'(bus.src_ready), 32'd1);

    // 6: reset mid-run with cnt=5
    drive(1'b1, mk(0, 0, 4'd10, 8'd3, 8'd3), 1'b1);
    cycle();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, '0, 1'b1);
      cycle();
    end
    drive(1'b0, '0, 1'b1);
    check("t6_running", 32'(bus.net_valid), 32'd1);
    arstn = 1'b0;
    #1;
    exp_q.delete();
    check_idle("t6_rst");
    cycle();
    arstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, '0, 1'b1);
      check("t6_quiet", 32'(bus.net_valid), 32'd0);
      cycle();
    end

    // 7: randomized packets with random host and network backpressure
    sent = 0;
    have = 1'b0;
    pend = '0;
    for (int c = 0; c < 4000 && (sent < 40 || have); c++) begin
      if (!have && sent < 40) begin
        r = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
        pend = mk(1'($urandom), 1'($urandom), r, 8'($urandom), 8'($urandom));
        have = 1'b1;
      end
      v = have && ($urandom_range(0, 3) != 0);
      drive(v, v ? pend : PW'($urandom), 1'($urandom_range(0, 3) != 0));
      if (v && bus.src_ready) begin
        have = 1'b0;
        sent++;
      end
      cycle();
    end
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
      drive(1'b0, '0, 1'b1);
      cycle();
    end
    drive(1'b0, '0, 1'b1);
    check("rand_sent", sent, 32'd40);
    check("rand_drained", exp_q.size(), 32'd0);
    check_idle("rand_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
